apb_regbank: RTL

APB_REGBANK -- requirements
Module: apb_regbank

---
 rtl/apb_regbank_if.sv | 25 ++
 rtl/apb_regbank.sv | 101 ++++++++++
 2 files changed

// File: rtl/apb_regbank_if.sv
// APB bus signals between a requester and the apb_regbank register file.
interface apb_regbank_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_W-1:0]     PADDR;
   logic [DATA_W-1:0]     PWDATA;
   logic [DATA_W/8-1:0]   PSTRB;
   logic [DATA_W-1:0]     PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_regbank.sv
// APB slave exposing NUM_REGS byte-strobed registers with error decode.
// Optional wait states are built in when APB_REGBANK_WAIT_EN is defined.
//
// state  | meaning
// IDLE   | no transfer; waiting for a setup phase (PSEL=1, PENABLE=0)
// SETUP  | address captured; moves to ACCESS next cycle
// ACCESS | completes when PREADY=1, abandoned when PSEL drops
module apb_regbank #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_CYCLES = 2
) (
   input logic            PCLK,
   input logic            PRESETn,
   apb_regbank_if.slave   bus
);
   localparam int BYTES = DATA_W / 8;
   localparam int AL    = $clog2(BYTES);
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_data_w
      $error("apb_regbank: DATA_W must be 8, 16 or 32");
   end
   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("apb_regbank: WAIT_CYCLES must be 0..15");
   end

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   idx_full;
   logic [IDX_W-1:0]    idx;
   logic                addr_err;
   logic                cnt_zero;
   logic                ready;
   logic                do_write;
   logic [DATA_W-1:0]   regs [NUM_REGS];

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.PSEL && !bus.PENABLE) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (!bus.PSEL || ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)            addr_q <= '0;
      else if (state == SETUP) addr_q <= bus.PADDR;
   end

`ifdef APB_REGBANK_WAIT_EN
   logic [3:0] wait_cnt;

   // Loaded on SETUP->ACCESS so the stall count restarts for every transfer.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         wait_cnt <= '0;
      else if (state == SETUP)
         wait_cnt <= 4'(WAIT_CYCLES);
      else if (state == ACCESS && wait_cnt != '0)
         wait_cnt <= wait_cnt - 4'd1;
   end

   assign cnt_zero = (wait_cnt == '0);
`else
   assign cnt_zero = 1'b1;
`endif

   assign idx_full = addr_q >> AL;
   assign idx      = idx_full[IDX_W-1:0];
   assign addr_err = ((addr_q & ADDR_W'(BYTES - 1)) != '0)
                  || (32'(idx_full) >= 32'(NUM_REGS));

   assign ready    = (state == ACCESS) && bus.PSEL && bus.PENABLE && cnt_zero;
   assign do_write = ready && bus.PWRITE && !addr_err;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (do_write) begin
         for (int b = 0; b < BYTES; b++) begin
            if (bus.PSTRB[b]) regs[idx][b*8 +: 8] <= bus.PWDATA[b*8 +: 8];
         end
      end
   end

   assign bus.PREADY  = ready;
   assign bus.PSLVERR = ready && addr_err;
   assign bus.PRDATA  = (ready && !bus.PWRITE && !addr_err) ? regs[idx] : '0;
endmodule
